// File: rtl/mul_pkg.sv
// mul_pkg: definitions shared by the Booth multiplier core and its
// downstream output-logic stage.
//   - mul_state_e   : exported FSM state encoding (IDLE/EXEC/DONE)
//   - DEFAULT_WIDTH : default operand width
//   - booth_sel_e   : Booth recode selection (0, +/-M, +/-2M)
// Optional build macro: BOOTH_RADIX4_EN selects radix-4 recoding
// (2 multiplier bits retired per step) instead of radix-2.
package mul_pkg;

    localparam int unsigned DEFAULT_WIDTH = 64;

`ifdef BOOTH_RADIX4_EN
    localparam int unsigned BOOTH_RADIX_BITS = 2;
`else
    localparam int unsigned BOOTH_RADIX_BITS = 1;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    typedef enum logic [2:0] {
        SEL_ZERO   = 3'd0,
        SEL_POS_M  = 3'd1,
        SEL_NEG_M  = 3'd2,
        SEL_POS_2M = 3'd3,
        SEL_NEG_2M = 3'd4
    } booth_sel_e;

    // Radix-4 recode of {q[i+1], q[i], q[i-1]}. A radix-2 pair {q[i], q[i-1]}
    // maps onto the same table as the window {q[i], q[i], q[i-1]}.
    function automatic booth_sel_e booth_recode(input logic [2:0] window);
        booth_sel_e sel;
        case (window)
            3'b001, 3'b010: sel = SEL_POS_M;
            3'b011:         sel = SEL_POS_2M;
            3'b100:         sel = SEL_NEG_2M;
            3'b101, 3'b110: sel = SEL_NEG_M;
            default:        sel = SEL_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/booth_step.sv
// booth_step: one combinational Booth iteration on {U, Q, q_-1}.
// Recodes the low multiplier bits, adds 0/+-M(/+-2M) into U, then
// arithmetic-shifts the whole {U, Q, q_-1} right by the radix bit count.
// Ports:
//   m       in  WIDTH     latched multiplicand
//   u_in    in  UW        upper accumulator (UW = WIDTH + radix bits)
//   q_in    in  WIDTH     multiplier / low product bits
//   qm1_in  in  1         q_-1
//   u_out, q_out, qm1_out  next-step values
// Optional build macro: BOOTH_RADIX4_EN (radix-4 window, shift by 2).
import mul_pkg::*;

module booth_step #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned UW    = WIDTH + BOOTH_RADIX_BITS
) (
    input  logic [WIDTH-1:0] m,
    input  logic [UW-1:0]    u_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qm1_in,
    output logic [UW-1:0]    u_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qm1_out
);

    logic [2:0]             window;
    booth_sel_e             sel;
    logic [UW-1:0]          m_ext;
    logic [UW-1:0]          m2_ext;
    logic [UW-1:0]          sum;
    logic signed [UW+WIDTH:0] wide;
    logic signed [UW+WIDTH:0] shifted;

`ifdef BOOTH_RADIX4_EN
    assign window = {q_in[1], q_in[0], qm1_in};
`else
    assign window = {q_in[0], q_in[0], qm1_in};
`endif

    assign sel    = booth_recode(window);
    assign m_ext  = {{BOOTH_RADIX_BITS{m[WIDTH-1]}}, m};
    assign m2_ext = {m_ext[UW-2:0], 1'b0};

    always_comb begin
        sum = u_in;
        case (sel)
            SEL_POS_M:  sum = u_in + m_ext;
            SEL_NEG_M:  sum = u_in - m_ext;
            SEL_POS_2M: sum = u_in + m2_ext;
            SEL_NEG_2M: sum = u_in - m2_ext;
            default:    sum = u_in;
        endcase
    end

    assign wide    = {sum, q_in, qm1_in};
    assign shifted = wide >>> BOOTH_RADIX_BITS;

    assign u_out   = shifted[UW+WIDTH:WIDTH+1];
    assign q_out   = shifted[WIDTH:1];
    assign qm1_out = shifted[0];

endmodule

// File: rtl/booth_mul_core.sv
// booth_mul_core: sequential signed Booth multiplier (FSM, counter, registers).
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   op_start     in   start request (ignored during EXEC)
//   op_clear     in   abort/clear, priority over op_start in every state
//   multiplicand in   WIDTH signed operand M
//   multiplier   in   WIDTH signed operand Q
//   state        out  FSM state (IDLE=00, EXEC=01, DONE=10)
//   cal_result   out  2*WIDTH product; partial in EXEC, final in DONE
// Optional build macro: BOOTH_RADIX4_EN (radix-4, WIDTH/2 steps).
import mul_pkg::*;

module booth_mul_core #(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [1:0]         state,
    output logic [2*WIDTH-1:0] cal_result
);

    localparam int unsigned UW    = WIDTH + BOOTH_RADIX_BITS;
    localparam int unsigned STEPS = WIDTH / BOOTH_RADIX_BITS;
    localparam int unsigned CW    = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

    mul_state_e         state_r;
    logic [WIDTH-1:0]   m_r;
    logic [UW-1:0]      u_r;
    logic [WIDTH-1:0]   q_r;
    logic               qm1_r;
    logic [CW-1:0]      count_r;
    logic [2*WIDTH-1:0] cal_result_r;

    logic [UW-1:0]      u_nxt;
    logic [WIDTH-1:0]   q_nxt;
    logic               qm1_nxt;

    booth_step #(
        .WIDTH (WIDTH),
        .UW    (UW)
    ) u_step (
        .m       (m_r),
        .u_in    (u_r),
        .q_in    (q_r),
        .qm1_in  (qm1_r),
        .u_out   (u_nxt),
        .q_out   (q_nxt),
        .qm1_out (qm1_nxt)
    );

    // Start is legal from IDLE and DONE (back-to-back); clear and illegal
    // encodings share one path back to an all-zero IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            m_r          <= '0;
            u_r          <= '0;
            q_r          <= '0;
            qm1_r        <= 1'b0;
            count_r      <= '0;
            cal_result_r <= '0;
        end else if (op_clear || !(state_r inside {IDLE, EXEC, DONE})) begin
            state_r      <= IDLE;
            m_r          <= '0;
            u_r          <= '0;
            q_r          <= '0;
            qm1_r        <= 1'b0;
            count_r      <= '0;
            cal_result_r <= '0;
        end else if (op_start && state_r != EXEC) begin
            state_r      <= EXEC;
            m_r          <= multiplicand;
            u_r          <= '0;
            q_r          <= multiplier;
            qm1_r        <= 1'b0;
            count_r      <= '0;
            cal_result_r <= {{WIDTH{1'b0}}, multiplier};
        end else if (state_r == EXEC) begin
            u_r          <= u_nxt;
            q_r          <= q_nxt;
            qm1_r        <= qm1_nxt;
            count_r      <= count_r + 1'b1;
            cal_result_r <= {u_nxt[WIDTH-1:0], q_nxt};
            if (count_r == LAST_COUNT) begin
                state_r <= DONE;
            end
        end
    end

    assign state      = state_r;
    assign cal_result = cal_result_r;

endmodule

// File: tb/tb_booth_mul_core.sv
import mul_pkg::*;

module tb_booth_mul_core;

`ifdef BOOTH_RADIX4_EN
    localparam int STEPS = 32;
`else
    localparam int STEPS = 64;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [63:0]  multiplicand = '0;
    logic [63:0]  multiplier = '0;
    logic [1:0]   state;
    logic [127:0] cal_result;

    int checks = 0;
    int failures = 0;
    int cyc;

    booth_mul_core #(.WIDTH(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .state        (state),
        .cal_result   (cal_result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [63:0] a, input logic [63:0] b);
        multiplicand = a;
        multiplier   = b;
        op_start     = 1'b1;
        tick();
        op_start     = 1'b0;
    endtask

    // Counts edges until DONE, bounded; returns cycle count (or -1 on timeout).
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 4 * STEPS; i++) begin
            tick();
            if (state == DONE) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #3;
        check("reset_state", 128'(state), 128'(IDLE));
        check("reset_result", cal_result, 128'h0);
        tick();
        reset = 1'b0;
        tick();

        // 3 x 5
        start_op(64'd3, 64'd5);
        check("3x5_exec", 128'(state), 128'(EXEC));
        wait_done(cyc);
        check("3x5_latency", 128'(cyc), 128'(STEPS));
        check("3x5_result", cal_result, 128'd15);
        repeat (5) tick();
        check("3x5_hold_state", 128'(state), 128'(DONE));
        check("3x5_hold_result", cal_result, 128'd15);

        // back-to-back from DONE: 2 x -4
        start_op(64'd2, 64'hFFFF_FFFF_FFFF_FFFC);
        check("b2b_exec", 128'(state), 128'(EXEC));
        wait_done(cyc);
        check("b2b_latency", 128'(cyc), 128'(STEPS));
        check("b2b_result", cal_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF8);

        // op_clear from DONE
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check("clear_done_state", 128'(state), 128'(IDLE));
        check("clear_done_result", cal_result, 128'h0);

        // -7 x 6
        start_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd6);
        wait_done(cyc);
        check("m7x6_result", cal_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6);

        // min x min
        start_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        wait_done(cyc);
        check("minxmin_result", cal_result, 128'h4000_0000_0000_0000_0000_0000_0000_0000);

        // max x -1
        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done(cyc);
        check("maxxm1_result", cal_result, 128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001);

        // -1 x min
        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        wait_done(cyc);
        check("m1xmin_result", cal_result, 128'h0000_0000_0000_0000_8000_0000_0000_0000);

        // operand change mid-EXEC: 1234 x -56 = -69104
        start_op(64'd1234, 64'hFFFF_FFFF_FFFF_FFC8);
        repeat (5) tick();
        multiplicand = 64'hDEAD_BEEF_0123_4567;
        multiplier   = 64'h0F0F_1234_5678_9ABC;
        op_start     = 1'b1;
        tick();
        op_start     = 1'b0;
        check("midchg_still_exec", 128'(state), 128'(EXEC));
        wait_done(cyc);
        check("midchg_latency", 128'(cyc + 6), 128'(STEPS));
        check("midchg_result", cal_result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE_F210);

        // op_clear at EXEC cycle 10
        start_op(64'd3, 64'd5);
        repeat (9) tick();
        check("clr10_pre_state", 128'(state), 128'(EXEC));
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check("clr10_state", 128'(state), 128'(IDLE));
        check("clr10_result", cal_result, 128'h0);
        repeat (3) tick();
        check("clr10_idle_hold", 128'(state), 128'(IDLE));

        // op_start with op_clear in IDLE
        multiplicand = 64'd9;
        multiplier   = 64'd9;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        tick();
        op_start     = 1'b0;
        op_clear     = 1'b0;
        check("startclr_state", 128'(state), 128'(IDLE));
        check("startclr_result", cal_result, 128'h0);

        // async reset at EXEC cycle 20
        start_op(64'd100, 64'd100);
        repeat (19) tick();
        check("rst20_pre_state", 128'(state), 128'(EXEC));
        #2;
        reset = 1'b1;
        #1;
        check("rst20_state", 128'(state), 128'(IDLE));
        check("rst20_result", cal_result, 128'h0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("rst20_idle_hold", 128'(state), 128'(IDLE));
        check("rst20_result_hold", cal_result, 128'h0);

        // illegal state encoding
        start_op(64'd3, 64'd5);
        wait_done(cyc);
        check("illegal_pre_result", cal_result, 128'd15);
        force dut.state_r = mul_state_e'(2'b11);
        #1;
        release dut.state_r;
        tick();
        check("illegal_state", 128'(state), 128'(IDLE));
        check("illegal_result", cal_result, 128'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
